// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone SRAM controller.
package wb_sram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRdWait,
        StAck
    } state_e;

    localparam int unsigned CNT_W = 32;

    // CSR byte offsets within the 16-byte window
    localparam logic [3:0] RD_CNT  = 4'h0;
    localparam logic [3:0] WR_CNT  = 4'h4;
    localparam logic [3:0] ERR_CNT = 4'h8;
    localparam logic [3:0] ID      = 4'hC;

    localparam logic [7:0] ID_BYTE = 8'hA5;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clear takes priority over increment.
module sat_counter
    import wb_sram_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave fronting a 1rw1r SRAM macro, with a small counter/ID CSR window.
module wb_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE = 32'h3000_0000,
    parameter logic [31:0] CSR_BASE  = 32'h3000_1000,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned AW        = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          csb0,
    output logic          web0,
    output logic [3:0]    wmask0,
    output logic [AW-1:0] addr0,
    output logic [31:0]   din0,
    output logic          csb1,
    output logic [AW-1:0] addr1,
    input  logic [31:0]   dout1,
    output logic          busy_o
);

    localparam logic [1:0]  LAT_MAX = 2'(READ_LAT);
    localparam logic [31:0] ID_WORD = {8'(READ_LAT), 16'h0000, ID_BYTE};

    state_e           state_q;
    logic [1:0]       lat_cnt_q;
    logic             rd_inc_q, wr_inc_q, err_inc_q, clr_q;
    logic [CNT_W-1:0] rd_cnt, wr_cnt, err_cnt;
    logic [31:0]      csr_rdata;
    logic             req, sram_hit, csr_hit;
    logic             unused_adr;

    assign req      = wbs_cyc_i && wbs_stb_i;
    assign sram_hit = wbs_adr_i[31:10] == SRAM_BASE[31:10];
    assign csr_hit  = wbs_adr_i[31:4] == CSR_BASE[31:4];
    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        csr_rdata = ID_WORD;
        case (wbs_adr_i[3:2])
            RD_CNT[3:2]:  csr_rdata = rd_cnt;
            WR_CNT[3:2]:  csr_rdata = wr_cnt;
            ERR_CNT[3:2]: csr_rdata = err_cnt;
            default:      csr_rdata = ID_WORD;
        endcase
    end

    // Counter pulses are registered, so they land on the edge that ends the ack cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= StIdle;
            lat_cnt_q <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            csb0      <= 1'b1;
            web0      <= 1'b1;
            wmask0    <= '0;
            addr0     <= '0;
            din0      <= '0;
            csb1      <= 1'b1;
            addr1     <= '0;
            busy_o    <= 1'b0;
            rd_inc_q  <= 1'b0;
            wr_inc_q  <= 1'b0;
            err_inc_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            rd_inc_q  <= 1'b0;
            wr_inc_q  <= 1'b0;
            err_inc_q <= 1'b0;
            clr_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        busy_o <= 1'b1;
                        if (sram_hit && wbs_we_i) begin
                            csb0    <= 1'b0;
                            web0    <= 1'b0;
                            addr0   <= wbs_adr_i[AW+1:2];
                            din0    <= wbs_dat_i;
                            wmask0  <= wbs_sel_i;
                            state_q <= StWr;
                        end else if (sram_hit) begin
                            csb1      <= 1'b0;
                            addr1     <= wbs_adr_i[AW+1:2];
                            lat_cnt_q <= '0;
                            state_q   <= StRdWait;
                        end else if (csr_hit) begin
                            if (wbs_we_i) begin
                                clr_q <= 1'b1;
                            end else begin
                                wbs_dat_o <= csr_rdata;
                            end
                            wbs_ack_o <= 1'b1;
                            state_q   <= StAck;
                        end else begin
                            if (!wbs_we_i) begin
                                wbs_dat_o <= '0;
                            end
                            err_inc_q <= 1'b1;
                            wbs_ack_o <= 1'b1;
                            state_q   <= StAck;
                        end
                    end
                end
                StWr: begin
                    csb0 <= 1'b1;
                    web0 <= 1'b1;
                    if (wbs_cyc_i) begin
                        wbs_ack_o <= 1'b1;
                        wr_inc_q  <= 1'b1;
                        state_q   <= StAck;
                    end else begin
                        busy_o  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRdWait: begin
                    csb1 <= 1'b1;
                    if (!wbs_cyc_i) begin
                        busy_o  <= 1'b0;
                        state_q <= StIdle;
                    end else if (lat_cnt_q == LAT_MAX) begin
                        wbs_dat_o <= dout1;
                        wbs_ack_o <= 1'b1;
                        rd_inc_q  <= 1'b1;
                        state_q   <= StAck;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                StAck: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    sat_counter u_rd_cnt (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n),
        .inc_i   (rd_inc_q),
        .clr_i   (clr_q),
        .count_o (rd_cnt)
    );

    sat_counter u_wr_cnt (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n),
        .inc_i   (wr_inc_q),
        .clr_i   (clr_q),
        .count_o (wr_cnt)
    );

    sat_counter u_err_cnt (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n),
        .inc_i   (err_inc_q),
        .clr_i   (clr_q),
        .count_o (err_cnt)
    );

endmodule
